// File: rtl/game_sequencer.sv
// Pong master sequencer: drives the renderer row scan, samples the paddle-neighbour bits
// once per frame and runs the ball/score state machine at each frame boundary.
module game_sequencer #(
    parameter int WIDTH        = 8,
    parameter int BIT_OF_WIDTH = 3,
    parameter int TICK_DIV     = 50000,
    parameter int MOVE_FRAMES  = 4,
    parameter int SERVE_FRAMES = 32,
    parameter int WIN_SCORE    = 9
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [WIDTH-1:0]            neighbour,
    output logic [BIT_OF_WIDTH-1:0]     count,
    output logic                        frame_done,
    output logic [2*BIT_OF_WIDTH-1:0]   pos_ball,
    output logic [1:0]                  state,
    output logic [3:0]                  score_top,
    output logic [3:0]                  score_down,
    output logic [1:0]                  miss_pulse
);

    localparam int BW     = BIT_OF_WIDTH;
    localparam int DIV_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 2;
    localparam int FR_MAX = (SERVE_FRAMES > MOVE_FRAMES) ? SERVE_FRAMES : MOVE_FRAMES;
    localparam int FR_W   = (FR_MAX > 1) ? $clog2(FR_MAX + 1) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    localparam logic [BW-1:0]    COORD_MIN  = BW'(1);
    localparam logic [BW-1:0]    COORD_MAX  = BW'(WIDTH - 2);
    localparam logic [BW-1:0]    CENTRE     = BW'(WIDTH / 2 - 1);
    localparam logic [BW-1:0]    ROW_FIRST  = '0;
    localparam logic [BW-1:0]    ROW_LAST   = BW'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_SAMPLE = DIV_W'(1);
    localparam logic [FR_W-1:0]  SERVE_LAST = FR_W'(SERVE_FRAMES - 1);
    localparam logic [FR_W-1:0]  MOVE_LAST  = FR_W'(MOVE_FRAMES - 1);
    localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic [BW-1:0]    count_q, count_d;
    logic             frameDone_q, frameDone_d;
    logic [2:0]       topNb_q, topNb_d;
    logic [2:0]       botNb_q, botNb_d;
    logic [1:0]       state_q, state_d;
    logic [FR_W-1:0]  frameCnt_q, frameCnt_d;
    logic [BW-1:0]    ballX_q, ballX_d;
    logic [BW-1:0]    ballY_q, ballY_d;
    logic             dxNeg_q, dxNeg_d;
    logic             dyNeg_q, dyNeg_d;
    logic [3:0]       scoreTop_q, scoreTop_d;
    logic [3:0]       scoreDown_q, scoreDown_d;
    logic [1:0]       missPulse_q, missPulse_d;

    logic [BW-1:0]    stepX, stepY;
    logic             stepDxNeg, stepDyNeg;
    logic             missTop, missBot;
    logic [3:0]       scoreTopInc, scoreDownInc;
    logic             unusedNb;

    assign unusedNb = ^neighbour[WIDTH-4:3];

    always_comb begin
        divCnt_d    = divCnt_q + DIV_W'(1);
        count_d     = count_q;
        frameDone_d = 1'b0;
        if (divCnt_q == DIV_LAST) begin
            divCnt_d    = '0;
            count_d     = (count_q == ROW_LAST) ? ROW_FIRST : count_q + BW'(1);
            frameDone_d = (count_q == ROW_LAST);
        end
    end

    // The renderer answers one clock after count moves, so sample on the row's second clock.
    always_comb begin
        topNb_d = topNb_q;
        botNb_d = botNb_q;
        if (frameDone_q) begin
            topNb_d = '0;
            botNb_d = '0;
        end else if (divCnt_q == DIV_SAMPLE) begin
            if (count_q == ROW_FIRST) topNb_d = neighbour[2:0];
            if (count_q == ROW_LAST)  botNb_d = neighbour[WIDTH-1 -: 3];
        end
    end

    always_comb begin
        stepDxNeg = dxNeg_q;
        stepDyNeg = dyNeg_q;
        missTop   = 1'b0;
        missBot   = 1'b0;
        if ((ballX_q == COORD_MIN && dxNeg_q) || (ballX_q == COORD_MAX && !dxNeg_q)) begin
            stepDxNeg = !dxNeg_q;
        end
        if (ballY_q == COORD_MIN && dyNeg_q) begin
            if (topNb_q[1]) begin
                stepDyNeg = 1'b0;
            end else if (stepDxNeg ? topNb_q[0] : topNb_q[2]) begin
                stepDyNeg = 1'b0;
                stepDxNeg = !stepDxNeg;
            end else begin
                missTop = 1'b1;
            end
        end else if (ballY_q == COORD_MAX && !dyNeg_q) begin
            if (botNb_q[1]) begin
                stepDyNeg = 1'b1;
            end else if (stepDxNeg ? botNb_q[0] : botNb_q[2]) begin
                stepDyNeg = 1'b1;
                stepDxNeg = !stepDxNeg;
            end else begin
                missBot = 1'b1;
            end
        end
        // An edge-bit deflection in a corner must not carry the ball through the side wall.
        if ((ballX_q == COORD_MIN && stepDxNeg) || (ballX_q == COORD_MAX && !stepDxNeg)) begin
            stepDxNeg = !stepDxNeg;
        end
        stepX = stepDxNeg ? ballX_q - BW'(1) : ballX_q + BW'(1);
        stepY = stepDyNeg ? ballY_q - BW'(1) : ballY_q + BW'(1);
    end

    assign scoreTopInc  = (scoreTop_q  == WIN) ? WIN : scoreTop_q  + 4'd1;
    assign scoreDownInc = (scoreDown_q == WIN) ? WIN : scoreDown_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        frameCnt_d  = frameCnt_q;
        ballX_d     = ballX_q;
        ballY_d     = ballY_q;
        dxNeg_d     = dxNeg_q;
        dyNeg_d     = dyNeg_q;
        scoreTop_d  = scoreTop_q;
        scoreDown_d = scoreDown_q;
        missPulse_d = 2'b00;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d     = ST_SERVE;
                    frameCnt_d  = '0;
                    scoreTop_d  = '0;
                    scoreDown_d = '0;
                    ballX_d     = CENTRE;
                    ballY_d     = CENTRE;
                    dxNeg_d     = 1'b0;
                    dyNeg_d     = 1'b1;
                end
            end
            ST_SERVE: begin
                if (frameDone_q) begin
                    if (frameCnt_q == SERVE_LAST) begin
                        state_d    = ST_PLAY;
                        frameCnt_d = '0;
                    end else begin
                        frameCnt_d = frameCnt_q + FR_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                if (frameDone_q) begin
                    if (frameCnt_q != MOVE_LAST) begin
                        frameCnt_d = frameCnt_q + FR_W'(1);
                    end else begin
                        frameCnt_d = '0;
                        if (missTop || missBot) begin
                            ballX_d = CENTRE;
                            ballY_d = CENTRE;
                            dxNeg_d = 1'b0;
                            // Next serve heads toward whoever just missed.
                            if (missTop) begin
                                missPulse_d = 2'b01;
                                scoreDown_d = scoreDownInc;
                                dyNeg_d     = 1'b1;
                                state_d     = (scoreDownInc == WIN) ? ST_OVER : ST_SERVE;
                            end else begin
                                missPulse_d = 2'b10;
                                scoreTop_d  = scoreTopInc;
                                dyNeg_d     = 1'b0;
                                state_d     = (scoreTopInc == WIN) ? ST_OVER : ST_SERVE;
                            end
                        end else begin
                            ballX_d = stepX;
                            ballY_d = stepY;
                            dxNeg_d = stepDxNeg;
                            dyNeg_d = stepDyNeg;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            divCnt_q    <= '0;
            count_q     <= '0;
            frameDone_q <= 1'b0;
            topNb_q     <= '0;
            botNb_q     <= '0;
            state_q     <= ST_IDLE;
            frameCnt_q  <= '0;
            ballX_q     <= CENTRE;
            ballY_q     <= CENTRE;
            dxNeg_q     <= 1'b0;
            dyNeg_q     <= 1'b1;
            scoreTop_q  <= '0;
            scoreDown_q <= '0;
            missPulse_q <= 2'b00;
        end else begin
            divCnt_q    <= divCnt_d;
            count_q     <= count_d;
            frameDone_q <= frameDone_d;
            topNb_q     <= topNb_d;
            botNb_q     <= botNb_d;
            state_q     <= state_d;
            frameCnt_q  <= frameCnt_d;
            ballX_q     <= ballX_d;
            ballY_q     <= ballY_d;
            dxNeg_q     <= dxNeg_d;
            dyNeg_q     <= dyNeg_d;
            scoreTop_q  <= scoreTop_d;
            scoreDown_q <= scoreDown_d;
            missPulse_q <= missPulse_d;
        end
    end

    assign count      = count_q;
    assign frame_done = frameDone_q;
    assign pos_ball   = {ballX_q, ballY_q};
    assign state      = state_q;
    assign score_top  = scoreTop_q;
    assign score_down = scoreDown_q;
    assign miss_pulse = missPulse_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: short frames (32 clocks) and a two-point game so
// full rallies, misses, game over and restart fit in a few thousand cycles.
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] neighbour;
    logic [2:0] count;
    logic       frame_done;
    logic [5:0] pos_ball;
    logic [1:0] state;
    logic [3:0] score_top;
    logic [3:0] score_down;
    logic [1:0] miss_pulse;

    int passCount  = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    game_sequencer #(
        .WIDTH(8), .BIT_OF_WIDTH(3), .TICK_DIV(4),
        .MOVE_FRAMES(1), .SERVE_FRAMES(2), .WIN_SCORE(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .neighbour(neighbour),
        .count(count), .frame_done(frame_done), .pos_ball(pos_ball), .state(state),
        .score_top(score_top), .score_down(score_down), .miss_pulse(miss_pulse)
    );

    // Waits for the next frame_done, then one more clock so the ball update is visible.
    task automatic nextFrame();
        int n;
        n = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (frame_done !== 1'b1) begin
            checkCount++;
            $display("[TB] FAIL frame_timeout: frame_done=%b after %0d clocks, required 1", frame_done, n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; neighbour = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkCount++; if (count !== 3'd0) $display("[TB] FAIL reset_count: got %0d required 0", count); else passCount++;
        checkCount++; if (frame_done !== 1'b0) $display("[TB] FAIL reset_frame_done: got %b required 0", frame_done); else passCount++;
        checkCount++; if (state !== 2'd0) $display("[TB] FAIL reset_state: got %0d required 0", state); else passCount++;
        checkCount++; if (pos_ball !== 6'o33) $display("[TB] FAIL reset_pos: got %o required 33", pos_ball); else passCount++;
        checkCount++; if ({score_top, score_down} !== 8'h00) $display("[TB] FAIL reset_scores: got %h required 00", {score_top, score_down}); else passCount++;
        checkCount++; if (miss_pulse !== 2'b00) $display("[TB] FAIL reset_miss: got %b required 00", miss_pulse); else passCount++;
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        int fdPulses;
        int fdAt;
        fdPulses = 0;
        fdAt = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                fdPulses++;
                fdAt = k;
            end
            if (k % 4 == 3) begin
                checkCount++;
                if (count !== 3'(k / 4)) $display("[TB] FAIL scan_row%0d: got %0d required %0d", k / 4, count, k / 4);
                else passCount++;
            end
        end
        checkCount++; if (count !== 3'd0) $display("[TB] FAIL scan_wrap: got %0d required 0", count); else passCount++;
        checkCount++; if (fdPulses != 1 || fdAt != 32) $display("[TB] FAIL frame_done_pulse: %0d pulses last at clk %0d, required 1 at 32", fdPulses, fdAt); else passCount++;
    endtask

    task automatic test_serve_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkCount++; if (state !== 2'd1) $display("[TB] FAIL start_to_serve: got %0d required 1", state); else passCount++;
        checkCount++; if (pos_ball !== 6'o33) $display("[TB] FAIL serve_pos: got %o required 33", pos_ball); else passCount++;
        nextFrame();
        checkCount++; if (state !== 2'd1) $display("[TB] FAIL serve_hold: got %0d required 1", state); else passCount++;
        nextFrame();
        checkCount++; if (state !== 2'd2) $display("[TB] FAIL serve_to_play: got %0d required 2", state); else passCount++;
        nextFrame();
        checkCount++; if (pos_ball !== 6'o42) $display("[TB] FAIL first_step: got %o required 42", pos_ball); else passCount++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkCount++; if (state !== 2'd2 || pos_ball !== 6'o42) $display("[TB] FAIL start_in_play: state %0d pos %o, required 2 42", state, pos_ball); else passCount++;
    endtask

    task automatic test_top_miss_rally();
        nextFrame();
        checkCount++; if (pos_ball !== 6'o51) $display("[TB] FAIL reach_top: got %o required 51", pos_ball); else passCount++;
        neighbour = 8'b0000_0100;
        nextFrame();
        checkCount++; if (pos_ball !== 6'o42) $display("[TB] FAIL top_edge_bounce: got %o required 42", pos_ball); else passCount++;
        neighbour = 8'h00;
        repeat (3) nextFrame();
        checkCount++; if (pos_ball !== 6'o15) $display("[TB] FAIL reach_left: got %o required 15", pos_ball); else passCount++;
        nextFrame();
        checkCount++; if (pos_ball !== 6'o26) $display("[TB] FAIL left_wall: got %o required 26", pos_ball); else passCount++;
        neighbour = 8'b0100_0000;
        nextFrame();
        checkCount++; if (pos_ball !== 6'o35) $display("[TB] FAIL bottom_centre_bounce: got %o required 35", pos_ball); else passCount++;
        neighbour = 8'h00;
        repeat (4) nextFrame();
        checkCount++; if (pos_ball !== 6'o51) $display("[TB] FAIL right_wall: got %o required 51", pos_ball); else passCount++;
        neighbour = 8'b0000_0100;
        nextFrame();
        checkCount++; if (miss_pulse !== 2'b01) $display("[TB] FAIL top_miss_pulse: got %b required 01", miss_pulse); else passCount++;
        checkCount++; if (score_down !== 4'd1 || score_top !== 4'd0) $display("[TB] FAIL top_miss_score: down %0d top %0d, required 1 0", score_down, score_top); else passCount++;
        checkCount++; if (state !== 2'd1 || pos_ball !== 6'o33) $display("[TB] FAIL top_miss_serve: state %0d pos %o, required 1 33", state, pos_ball); else passCount++;
        @(negedge clk);
        checkCount++; if (miss_pulse !== 2'b00) $display("[TB] FAIL miss_pulse_width: got %b required 00", miss_pulse); else passCount++;
        neighbour = 8'h00;
    endtask

    task automatic test_bottom_miss_rally();
        repeat (3) nextFrame();
        checkCount++; if (pos_ball !== 6'o42) $display("[TB] FAIL serve_dir_top: got %o required 42", pos_ball); else passCount++;
        nextFrame();
        neighbour = 8'b0000_0010;
        nextFrame();
        checkCount++; if (pos_ball !== 6'o62) $display("[TB] FAIL top_centre_bounce: got %o required 62", pos_ball); else passCount++;
        neighbour = 8'h00;
        repeat (4) nextFrame();
        checkCount++; if (pos_ball !== 6'o26) $display("[TB] FAIL reach_bottom: got %o required 26", pos_ball); else passCount++;
        nextFrame();
        checkCount++; if (miss_pulse !== 2'b10 || score_top !== 4'd1) $display("[TB] FAIL bottom_miss: pulse %b top %0d, required 10 1", miss_pulse, score_top); else passCount++;
        checkCount++; if (state !== 2'd1) $display("[TB] FAIL bottom_miss_serve: got %0d required 1", state); else passCount++;
        repeat (3) nextFrame();
        checkCount++; if (pos_ball !== 6'o44) $display("[TB] FAIL serve_dir_bottom: got %o required 44", pos_ball); else passCount++;
        repeat (2) nextFrame();
        checkCount++; if (pos_ball !== 6'o66) $display("[TB] FAIL reach_corner: got %o required 66", pos_ball); else passCount++;
        nextFrame();
        checkCount++; if (state !== 2'd3 || score_top !== 4'd2) $display("[TB] FAIL game_over: state %0d top %0d, required 3 2", state, score_top); else passCount++;
        checkCount++; if (miss_pulse !== 2'b10 || pos_ball !== 6'o33) $display("[TB] FAIL game_over_ball: pulse %b pos %o, required 10 33", miss_pulse, pos_ball); else passCount++;
    endtask

    task automatic test_over_restart();
        nextFrame();
        checkCount++; if (state !== 2'd3 || score_top !== 4'd2 || score_down !== 4'd1) $display("[TB] FAIL over_hold: state %0d top %0d down %0d, required 3 2 1", state, score_top, score_down); else passCount++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkCount++; if (state !== 2'd1 || {score_top, score_down} !== 8'h00) $display("[TB] FAIL restart: state %0d scores %h, required 1 00", state, {score_top, score_down}); else passCount++;
        repeat (3) nextFrame();
        checkCount++; if (state !== 2'd2 || pos_ball !== 6'o42) $display("[TB] FAIL restart_serve_dir: state %0d pos %o, required 2 42", state, pos_ball); else passCount++;
    endtask

    task automatic test_reset_midgame();
        repeat (9) @(negedge clk);
        checkCount++; if (count !== 3'd2) $display("[TB] FAIL pre_reset_count: got %0d required 2", count); else passCount++;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkCount++; if (count !== 3'd0 || frame_done !== 1'b0) $display("[TB] FAIL midgame_reset_scan: count %0d fd %b, required 0 0", count, frame_done); else passCount++;
        checkCount++; if (state !== 2'd0 || pos_ball !== 6'o33) $display("[TB] FAIL midgame_reset_ball: state %0d pos %o, required 0 33", state, pos_ball); else passCount++;
        checkCount++; if ({score_top, score_down, miss_pulse} !== 10'd0) $display("[TB] FAIL midgame_reset_score: got %h required 0", {score_top, score_down, miss_pulse}); else passCount++;
        nextFrame();
        checkCount++; if (state !== 2'd0 || pos_ball !== 6'o33) $display("[TB] FAIL idle_after_reset: state %0d pos %o, required 0 33", state, pos_ball); else passCount++;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_serve_start();
        test_top_miss_rally();
        test_bottom_miss_rally();
        test_over_restart();
        test_reset_midgame();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
